// File: rtl/rcb_frl_event_counter_if.sv
// Control, status and snapshot signals of the FRL event counter, grouped for port hookup.
// The master side drives commands and consumes the count and snapshot.
interface rcb_frl_event_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             count;
    logic             dir;
    logic [WIDTH-1:0] counter_value;
    logic             at_terminal;
    logic             wrap_pulse;
    logic             overflow_sticky;
    logic             snap_req;
    logic             snap_ack;
    logic [WIDTH-1:0] snap_value;
    logic             snap_valid;
    logic             snap_miss;

    modport master (
        output clr, load, load_value, count, dir, snap_req, snap_ack,
        input  counter_value, at_terminal, wrap_pulse, overflow_sticky,
        input  snap_value, snap_valid, snap_miss
    );

    modport slave (
        input  clr, load, load_value, count, dir, snap_req, snap_ack,
        output counter_value, at_terminal, wrap_pulse, overflow_sticky,
        output snap_value, snap_valid, snap_miss
    );
endinterface

// File: rtl/rcb_frl_event_counter.sv
// Parametrised up/down event counter with wrap/saturate, sticky overflow and a
// valid/ack snapshot port so a slow control path can sample the live count.
module rcb_frl_event_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VALUE = 15,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    rcb_frl_event_counter_if.slave     bus
);

    if (WIDTH < 1 || WIDTH > 32 || MAX_VALUE == 0 ||
        64'(MAX_VALUE) > ((64'd1 << WIDTH) - 64'd1)) begin : gen_bad_params
        $error("rcb_frl_event_counter: MAX_VALUE must be in 1..2^WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VALUE);

    typedef enum logic [0:0] {StIdle, StHold} snap_state_e;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    snap_state_e      state_q, state_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic             miss_q, miss_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (bus.clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            cnt_d = (bus.load_value > MaxV) ? MaxV : bus.load_value;
        end else if (bus.count) begin
            if (!bus.dir) begin
                if (cnt_q < MaxV) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end else begin
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                    cnt_d  = SATURATE ? MaxV : '0;
                end
            end else begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WIDTH'(1);
                end else begin
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                    cnt_d  = SATURATE ? '0 : MaxV;
                end
            end
        end
    end

    // Snapshot captures the pre-update count; clr deliberately has no effect here.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        miss_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.snap_req) begin
                    snap_d  = cnt_q;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.snap_ack) begin
                    if (bus.snap_req) begin
                        snap_d = cnt_q;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (bus.snap_req) begin
                    miss_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= StIdle;
            snap_q  <= '0;
            miss_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            snap_q  <= snap_d;
            miss_q  <= miss_d;
        end
    end

    assign bus.counter_value   = cnt_q;
    assign bus.at_terminal     = bus.dir ? (cnt_q == '0) : (cnt_q == MaxV);
    assign bus.wrap_pulse      = wrap_q;
    assign bus.overflow_sticky = ovf_q;
    assign bus.snap_value      = snap_q;
    assign bus.snap_valid      = (state_q == StHold);
    assign bus.snap_miss       = miss_q;

endmodule

// File: tb/tb_rcb_frl_event_counter.sv
// Drives a wrapping and a saturating counter (MAX_VALUE=9) with identical stimulus and
// compares both against a behavioural model after every clock.
module tb_rcb_frl_event_counter;

    localparam int unsigned W   = 4;
    localparam int unsigned MAX = 9;

    logic clk = 1'b0;
    logic rst, clr, load, count, dir, snap_req, snap_ack;
    logic [W-1:0] load_value;

    int checks = 0;
    int errors = 0;

    // Reference state per instance: index 0 wraps, index 1 saturates.
    int m_cnt[2], m_sv[2];
    bit m_wrap[2], m_ovf[2], m_valid[2], m_miss[2];

    rcb_frl_event_counter_if #(.WIDTH(W)) if0 ();
    rcb_frl_event_counter_if #(.WIDTH(W)) if1 ();

    assign if0.clr = clr;           assign if1.clr = clr;
    assign if0.load = load;         assign if1.load = load;
    assign if0.load_value = load_value; assign if1.load_value = load_value;
    assign if0.count = count;       assign if1.count = count;
    assign if0.dir = dir;           assign if1.dir = dir;
    assign if0.snap_req = snap_req; assign if1.snap_req = snap_req;
    assign if0.snap_ack = snap_ack; assign if1.snap_ack = snap_ack;

    rcb_frl_event_counter #(.WIDTH(W), .MAX_VALUE(MAX), .SATURATE(1'b0)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    rcb_frl_event_counter #(.WIDTH(W), .MAX_VALUE(MAX), .SATURATE(1'b1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                m_cnt[s] = 0; m_wrap[s] = 0; m_ovf[s] = 0;
                m_sv[s] = 0; m_valid[s] = 0; m_miss[s] = 0;
            end else begin
                m_miss[s] = 0;
                if (!m_valid[s]) begin
                    if (snap_req) begin m_sv[s] = m_cnt[s]; m_valid[s] = 1; end
                end else if (snap_ack) begin
                    if (snap_req) m_sv[s] = m_cnt[s];
                    else m_valid[s] = 0;
                end else if (snap_req) begin
                    m_miss[s] = 1;
                end
                m_wrap[s] = 0;
                if (clr) begin
                    m_cnt[s] = 0; m_ovf[s] = 0;
                end else if (load) begin
                    m_cnt[s] = (int'(load_value) > MAX) ? MAX : int'(load_value);
                end else if (count) begin
                    int nxt;
                    nxt = dir ? m_cnt[s] - 1 : m_cnt[s] + 1;
                    if (nxt < 0 || nxt > MAX) begin
                        m_wrap[s] = 1; m_ovf[s] = 1;
                        if (s == 1) m_cnt[s] = (nxt < 0) ? 0 : MAX;
                        else m_cnt[s] = (nxt < 0) ? MAX : 0;
                    end else begin
                        m_cnt[s] = nxt;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int s = 0; s < 2; s++) begin
            bit term;
            term = dir ? (m_cnt[s] == 0) : (m_cnt[s] == MAX);
            if (s == 0) begin
                chk("wrap.count", 32'(if0.counter_value), m_cnt[s]);
                chk("wrap.at_terminal", 32'(if0.at_terminal), 32'(term));
                chk("wrap.wrap_pulse", 32'(if0.wrap_pulse), 32'(m_wrap[s]));
                chk("wrap.sticky", 32'(if0.overflow_sticky), 32'(m_ovf[s]));
                chk("wrap.snap_value", 32'(if0.snap_value), m_sv[s]);
                chk("wrap.snap_valid", 32'(if0.snap_valid), 32'(m_valid[s]));
                chk("wrap.snap_miss", 32'(if0.snap_miss), 32'(m_miss[s]));
            end else begin
                chk("sat.count", 32'(if1.counter_value), m_cnt[s]);
                chk("sat.at_terminal", 32'(if1.at_terminal), 32'(term));
                chk("sat.wrap_pulse", 32'(if1.wrap_pulse), 32'(m_wrap[s]));
                chk("sat.sticky", 32'(if1.overflow_sticky), 32'(m_ovf[s]));
                chk("sat.snap_value", 32'(if1.snap_value), m_sv[s]);
                chk("sat.snap_valid", 32'(if1.snap_valid), 32'(m_valid[s]));
                chk("sat.snap_miss", 32'(if1.snap_miss), 32'(m_miss[s]));
            end
        end
    endtask

    // Inputs are changed 1 time unit after the edge, outputs sampled at the same point.
    task automatic step(input bit r, input bit c, input bit l, input int lv, input bit cn,
                        input bit d, input bit rq, input bit ak);
        rst = r; clr = c; load = l; load_value = W'(lv); count = cn; dir = d;
        snap_req = rq; snap_ack = ak;
        @(posedge clk);
        #1;
        model_update();
        check_all();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; load_value = '0; count = 1'b0; dir = 1'b0;
        snap_req = 1'b0; snap_ack = 1'b0;

        step(1, 0, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.count", 32'(if0.counter_value), 0);
        chk("reset.valid", 32'(if1.snap_valid), 0);

        // Count up 12 cycles through the wrap.
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0);
            chk("up.seq", 32'(if0.counter_value), 32'(i % 10));
            chk("up.pulse", 32'(if0.wrap_pulse), 32'(i == 10));
            chk("up.sticky", 32'(if0.overflow_sticky), 32'(i >= 10));
        end

        // Saturating up from 8.
        step(0, 0, 1, 8, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0);
            chk("sat.seq", 32'(if1.counter_value), 9);
            chk("sat.pulse", 32'(if1.wrap_pulse), 32'(i >= 2));
        end

        // Down from 1 through zero.
        step(0, 0, 1, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        chk("down.zero_term", 32'(if0.at_terminal), 1);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        chk("down.wrap_to_max", 32'(if0.counter_value), 9);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        chk("down.eight", 32'(if0.counter_value), 8);

        // Priority and load clamp.
        step(0, 1, 1, 5, 1, 0, 0, 0);
        chk("prio.clr_count", 32'(if0.counter_value), 0);
        chk("prio.clr_sticky", 32'(if0.overflow_sticky), 0);
        step(0, 0, 1, 15, 0, 0, 0, 0);
        chk("prio.clamp", 32'(if0.counter_value), 9);

        // Snapshot handshake.
        step(0, 0, 1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("snap.first", 32'(if0.snap_value), 3);
        step(0, 0, 1, 7, 0, 0, 1, 0);
        chk("snap.miss", 32'(if0.snap_miss), 1);
        chk("snap.kept", 32'(if0.snap_value), 3);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        chk("snap.recapture", 32'(if0.snap_value), 7);
        chk("snap.still_valid", 32'(if0.snap_valid), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("snap.released", 32'(if0.snap_valid), 0);

        // Reset while holding a snapshot and counting.
        step(0, 0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 1, 0);
        chk("rst_hold.valid", 32'(if1.snap_valid), 0);
        chk("rst_hold.snap", 32'(if1.snap_value), 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
                 int'($urandom_range(15)), $urandom_range(3) != 0, 1'($urandom_range(1)),
                 $urandom_range(3) == 0, $urandom_range(2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
